debug_bus_master: RTL and testbench
===================================

DEBUG_BUS_MASTER -- requirements
Module: debug_bus_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1024: the maximum number of STROBE or RELEASE cycles before a cycle is abandoned, with a legal range of 2..65535.
REQ-002 SHALL have one clock and an asynchronous, active-high reset, with these ports:
- clk8  in  1  clock
- reset  in  1  asynchronous active-high reset
REQ-003 SHALL have this command and response interface:
- cmdValid  in  1  command request
- cmdReady  out  1  module idle; command accepted when cmdValid&&cmdReady at posedge
- cmdWrite  in  1  1=write, 0=read
- cmdAddr  in  24  byte address; bit0 ignored
- cmdByteEn  in  2  {upper,lower} byte enables
- cmdData  in  16  write data
- rspValid  out  1  one-cycle completion pulse
- rspData  out  16  read data, held until next accept
- rspTimeout  out  1  completion was a timeout, held until next accept
REQ-004 SHALL have this bus interface:
- busRequest  out  1  bus ownership request
- busGrant  in  1  bus granted (CPU halted / not video slot)
- busAddr  out  24  bus address, bit0 always 0
- _busRW  out  1  low=write
- _busAS  out  1  address strobe, active-low
- _busUDS, _busLDS  out  1 each  data strobes, active-low
- busDataOut  out  16  write data
- busDataOE  out  1  drive busDataOut
- _dtackIn  in  1  responder acknowledge, active-low
- busDataIn  in  16  read data

Function
REQ-005 SHALL be a registered FSM with states IDLE, REQ, ADDR, STROBE, RELEASE and DONE; all outputs SHALL be registered or decoded from the state register only.
REQ-006 SHALL assert cmdReady only in IDLE; on accept it SHALL latch cmd* into internal registers, clear rspTimeout and move to REQ.
REQ-007 SHALL treat cmdByteEn=00 as 11.
REQ-008 SHALL assert busRequest in REQ, ADDR, STROBE and RELEASE; in REQ it SHALL wait indefinitely for busGrant=1 and then go to ADDR.
REQ-009 SHALL, in ADDR, drive busAddr={cmdAddr[23:1],0} and _busRW=~cmdWrite, keep all strobes high, assert busDataOE=cmdWrite with busDataOut=cmdData, and last exactly one cycle.
REQ-010 SHALL, in STROBE, hold _busAS=0 and _busUDS/_busLDS=~byteEn with address, RW and data held; it SHALL sample _dtackIn each posedge and go to RELEASE when it is 0.
REQ-011 SHALL capture busDataIn into rspData on the posedge that samples _dtackIn=0 in STROBE for reads; writes SHALL leave rspData unchanged.
REQ-012 SHALL count STROBE cycles from 0; at count TIMEOUT-1 without DTACK it SHALL go to RELEASE, set rspTimeout=1 and set rspData=0.
REQ-013 SHALL, in RELEASE, negate all strobes while holding address, RW and busDataOE; it SHALL wait for _dtackIn=1, or for TIMEOUT cycles with rspTimeout set, then go to DONE.
REQ-014 SHALL, in DONE, pulse rspValid for exactly one cycle, drop busRequest and busDataOE, and return to IDLE.
REQ-015 SHALL ignore busGrant falling after ADDR is entered, so that a started cycle always completes.
REQ-016 SHALL ignore cmdValid while not in IDLE.
REQ-017 SHALL have a best-case latency with no wait states of: accept at edge N; ADDR N+1; STROBE N+2; DTACK sampled N+3; DTACK-high sampled N+4; rspValid high N+4..N+5.

Reset
REQ-018 SHALL, on asynchronous reset (including mid-cycle), immediately force state=IDLE, busRequest=0, _busAS=_busUDS=_busLDS=_busRW=1, busDataOE=0, busAddr=0, busDataOut=0, rspValid=0, rspTimeout=0, rspData=0, counter=0 and cmdReady=1 after release.
REQ-019 SHALL not emit rspValid for a command aborted by reset.

Verification
REQ-020 The bench SHALL check a zero-wait read: busGrant=1, read 0x400000 with byteEn=11, responder DTACK on the first STROBE cycle returning 0x4E75 -> rspData=0x4E75, rspTimeout=0, _busUDS=_busLDS=0 during STROBE, rspValid at N+4.
REQ-021 The bench SHALL check a lower-byte write: write 0x000123 (busAddr 0x000122), byteEn=01, data 0x00AB, 3-cycle DTACK delay -> _busUDS=1, _busLDS=0, _busRW=0, busDataOE=1 ADDR..RELEASE, rspData unchanged.
REQ-022 The bench SHALL check a timeout: TIMEOUT=8, no DTACK -> exactly 8 STROBE cycles, rspTimeout=1, rspData=0, single rspValid pulse, strobes high afterward.
REQ-023 The bench SHALL check a grant delay: busGrant=0 for 20 cycles after accept -> busRequest=1 and strobes high throughout; ADDR starts the cycle after busGrant rises; busGrant dropping during STROBE does not abort.
REQ-024 The bench SHALL check reset mid-STROBE -> all strobes high and busRequest=0 asynchronously, no rspValid, and a new command is accepted after reset release.
REQ-025 The bench SHALL check back-to-back commands: cmdValid held high -> second accept only after rspValid, cmdReady=0 from accept through DONE, and a stuck-low _dtackIn in RELEASE is resolved by timeout.

Source files
------------

// File: rtl/debug_bus_master.sv
// Single-word bus master for a 68000-style asynchronous bus: takes one command,
// arbitrates for the bus, runs one AS/DS/DTACK cycle and reports the result.
module debug_bus_master #(
    parameter int TIMEOUT = 1024
) (
    input  logic        clk8,
    input  logic        reset,
    input  logic        cmdValid,
    output logic        cmdReady,
    input  logic        cmdWrite,
    input  logic [23:0] cmdAddr,
    input  logic [1:0]  cmdByteEn,
    input  logic [15:0] cmdData,
    output logic        rspValid,
    output logic [15:0] rspData,
    output logic        rspTimeout,
    output logic        busRequest,
    input  logic        busGrant,
    output logic [23:0] busAddr,
    output logic        _busRW,
    output logic        _busAS,
    output logic        _busUDS,
    output logic        _busLDS,
    output logic [15:0] busDataOut,
    output logic        busDataOE,
    input  logic        _dtackIn,
    input  logic [15:0] busDataIn
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        ADDR    = 3'd2,
        STROBE  = 3'd3,
        RELEASE = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        write_q, write_d;
    logic [23:0] addr_q, addr_d;
    logic [1:0]  be_q, be_d;
    logic [15:0] data_q, data_d;
    logic [15:0] rdata_q, rdata_d;
    logic        tmo_q, tmo_d;
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        addr_d  = addr_q;
        be_d    = be_q;
        data_d  = data_q;
        rdata_d = rdata_q;
        tmo_d   = tmo_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (cmdValid) begin
                    write_d = cmdWrite;
                    addr_d  = {cmdAddr[23:1], cmdAddr[0] & 1'b0};
                    // No enables at all means a full word access.
                    be_d    = (cmdByteEn == 2'b00) ? 2'b11 : cmdByteEn;
                    data_d  = cmdData;
                    tmo_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (busGrant) state_d = ADDR;
            end
            ADDR: begin
                cnt_d   = '0;
                state_d = STROBE;
            end
            STROBE: begin
                if (!_dtackIn) begin
                    if (!write_q) rdata_d = busDataIn;
                    cnt_d   = '0;
                    state_d = RELEASE;
                end else if (cnt_q == CNT_LAST) begin
                    tmo_d   = 1'b1;
                    rdata_d = '0;
                    cnt_d   = '0;
                    state_d = RELEASE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RELEASE: begin
                // A responder that never lets go of DTACK must not hang us.
                if (_dtackIn) begin
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DONE: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk8 or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            addr_q  <= '0;
            be_q    <= 2'b00;
            data_q  <= '0;
            rdata_q <= '0;
            tmo_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            data_q  <= data_d;
            rdata_q <= rdata_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
        end
    end

    logic in_cycle;
    assign in_cycle   = (state_q == ADDR) || (state_q == STROBE) || (state_q == RELEASE);

    assign cmdReady   = (state_q == IDLE);
    assign rspValid   = (state_q == DONE);
    assign rspData    = rdata_q;
    assign rspTimeout = tmo_q;
    assign busRequest = (state_q == REQ) || in_cycle;
    assign busAddr    = addr_q;
    assign busDataOut = data_q;
    assign busDataOE  = in_cycle && write_q;
    assign _busRW     = ~(in_cycle && write_q);
    assign _busAS     = ~(state_q == STROBE);
    assign _busUDS    = ~((state_q == STROBE) && be_q[1]);
    assign _busLDS    = ~((state_q == STROBE) && be_q[0]);

endmodule

// File: tb/tb_debug_bus_master.sv
// Directed bench for debug_bus_master: a scoreboard queue holds the expected
// response of each command, popped when rspValid is seen.
module tb_debug_bus_master;

    logic        clk8 = 1'b0;
    logic        reset;
    logic        cmdValid, cmdReady, cmdWrite;
    logic [23:0] cmdAddr;
    logic [1:0]  cmdByteEn;
    logic [15:0] cmdData;
    logic        rspValid, rspTimeout;
    logic [15:0] rspData;
    logic        busRequest, busGrant;
    logic [23:0] busAddr;
    logic        _busRW, _busAS, _busUDS, _busLDS;
    logic [15:0] busDataOut;
    logic        busDataOE;
    logic        _dtackIn;
    logic [15:0] busDataIn;

    debug_bus_master #(.TIMEOUT(8)) dut (
        .clk8(clk8), .reset(reset),
        .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdWrite(cmdWrite),
        .cmdAddr(cmdAddr), .cmdByteEn(cmdByteEn), .cmdData(cmdData),
        .rspValid(rspValid), .rspData(rspData), .rspTimeout(rspTimeout),
        .busRequest(busRequest), .busGrant(busGrant), .busAddr(busAddr),
        ._busRW(_busRW), ._busAS(_busAS), ._busUDS(_busUDS), ._busLDS(_busLDS),
        .busDataOut(busDataOut), .busDataOE(busDataOE),
        ._dtackIn(_dtackIn), .busDataIn(busDataIn)
    );

    always #5 clk8 = ~clk8;

    typedef struct {
        logic [15:0] data;
        logic        tmo;
    } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc = 0;
    int rsp_count = 0;

    // Responder: DTACK after dtack_dly strobe cycles; stuck holds it low after AS.
    int   as_cnt = 0;
    int   dtack_dly = 0;
    logic dtack_en = 1'b1;
    logic stuck = 1'b0;

    // Per-response observations gathered by wait_rsp.
    int          n_strobe, oe_n, rdy_hi, lat;
    logic        seen;
    logic        uds_s, lds_s, rw_s;
    logic [23:0] addr_s;
    logic [15:0] dout_s;
    logic [15:0] last_rd;

    always @(posedge clk8) cyc <= cyc + 1;

    always @(negedge clk8) begin
        if (rspValid === 1'b1) rsp_count++;
        if (_busAS === 1'b0) begin
            as_cnt++;
            _dtackIn = !(dtack_en && as_cnt > dtack_dly);
        end else begin
            as_cnt = 0;
            _dtackIn = !stuck;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic w, input logic [23:0] a, input logic [1:0] be,
                         input logic [15:0] d);
        cmdWrite  = w;
        cmdAddr   = a;
        cmdByteEn = be;
        cmdData   = d;
        cmdValid  = 1'b1;
        @(negedge clk8);
        acc = cyc;
        chk("accept_ready_low", {31'd0, cmdReady}, 32'd0);
        cmdValid = 1'b0;
    endtask

    task automatic wait_rsp();
        exp_t e;
        logic got;
        got = 1'b0;
        n_strobe = 0; oe_n = 0; rdy_hi = 0; seen = 1'b0;
        for (int n = 0; n < 300 && !got; n++) begin
            @(negedge clk8);
            if (cmdReady) rdy_hi++;
            if (busDataOE) oe_n++;
            if (!_busAS) begin
                n_strobe++;
                if (!seen) begin
                    uds_s = _busUDS; lds_s = _busLDS; rw_s = _busRW;
                    addr_s = busAddr; dout_s = busDataOut;
                end
                seen = 1'b1;
            end
            if (rspValid) got = 1'b1;
        end
        lat = cyc - acc;
        chk("rsp_seen", {31'd0, got}, 32'd1);
        if (got) begin
            if (sb.size() == 0) begin
                chk("sb_empty", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                $display("rsp data=%h tmo=%0d lat=%0d strobes=%0d", rspData, rspTimeout, lat, n_strobe);
                chk("rsp_data", {16'd0, rspData}, {16'd0, e.data});
                chk("rsp_tmo", {31'd0, rspTimeout}, {31'd0, e.tmo});
            end
            chk("ready_low_busy", 32'(rdy_hi), 32'd0);
        end
    endtask

    task automatic post_chk();
        @(negedge clk8);
        chk("post_rspvalid", {31'd0, rspValid}, 32'd0);
        chk("post_strobes", {29'd0, _busAS, _busUDS, _busLDS}, 32'd7);
        chk("post_busreq", {31'd0, busRequest}, 32'd0);
        chk("post_oe", {31'd0, busDataOE}, 32'd0);
        chk("post_ready", {31'd0, cmdReady}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int viol;
        int rc;
        reset = 1'b1; cmdValid = 1'b0; cmdWrite = 1'b0; cmdAddr = '0;
        cmdByteEn = 2'b00; cmdData = '0; busGrant = 1'b1; busDataIn = '0;
        _dtackIn = 1'b1;
        repeat (3) @(negedge clk8);
        reset = 1'b0;
        @(negedge clk8);
        chk("rst_ready", {31'd0, cmdReady}, 32'd1);
        chk("rst_busreq", {31'd0, busRequest}, 32'd0);
        chk("rst_strobes_rw", {28'd0, _busAS, _busUDS, _busLDS, _busRW}, 32'hF);
        chk("rst_oe", {31'd0, busDataOE}, 32'd0);
        chk("rst_addr", {8'd0, busAddr}, 32'd0);
        chk("rst_dout", {16'd0, busDataOut}, 32'd0);
        chk("rst_rsp", {14'd0, rspValid, rspTimeout, rspData}, 32'd0);

        // Zero-wait read.
        dtack_dly = 0; dtack_en = 1'b1; busDataIn = 16'h4E75;
        sb.push_back('{16'h4E75, 1'b0});
        issue(1'b0, 24'h400000, 2'b11, 16'h0000);
        wait_rsp();
        chk("rd_latency", 32'(lat), 32'd4);
        chk("rd_ds", {30'd0, uds_s, lds_s}, 32'd0);
        chk("rd_rw", {31'd0, rw_s}, 32'd1);
        chk("rd_addr", {8'd0, addr_s}, 32'h400000);
        chk("rd_strobes", 32'(n_strobe), 32'd1);
        post_chk();
        last_rd = 16'h4E75;

        // Lower-byte write with 3 wait states.
        dtack_dly = 3; busDataIn = 16'hFFFF;
        sb.push_back('{last_rd, 1'b0});
        issue(1'b1, 24'h000123, 2'b01, 16'h00AB);
        wait_rsp();
        chk("wr_ds", {30'd0, uds_s, lds_s}, 32'd2);
        chk("wr_rw", {31'd0, rw_s}, 32'd0);
        chk("wr_addr", {8'd0, addr_s}, 32'h000122);
        chk("wr_dout", {16'd0, dout_s}, 32'h00AB);
        chk("wr_oe_cycles", 32'(oe_n), 32'd6);
        chk("wr_strobes", 32'(n_strobe), 32'd4);
        post_chk();

        // No DTACK: strobe phase abandoned after TIMEOUT cycles.
        dtack_en = 1'b0;
        rc = rsp_count;
        sb.push_back('{16'h0000, 1'b1});
        issue(1'b0, 24'h000200, 2'b11, 16'h0000);
        wait_rsp();
        chk("tmo_strobes", 32'(n_strobe), 32'd8);
        post_chk();
        #1;
        chk("tmo_one_pulse", 32'(rsp_count - rc), 32'd1);
        last_rd = 16'h0000;

        // Grant delay, zero byte enables, grant dropped mid-strobe.
        dtack_en = 1'b1; dtack_dly = 2; busGrant = 1'b0;
        sb.push_back('{last_rd, 1'b0});
        issue(1'b1, 24'h000300, 2'b00, 16'hCAFE);
        viol = 0;
        repeat (20) begin
            @(negedge clk8);
            if (!busRequest || !_busAS || !_busUDS || !_busLDS) viol++;
        end
        chk("grant_wait", 32'(viol), 32'd0);
        busGrant = 1'b1;
        @(negedge clk8);
        chk("grant_addr_oe", {31'd0, busDataOE}, 32'd1);
        chk("grant_addr_as", {31'd0, _busAS}, 32'd1);
        @(negedge clk8);
        chk("grant_strobe", {29'd0, _busAS, _busUDS, _busLDS}, 32'd0);
        busGrant = 1'b0;
        wait_rsp();
        post_chk();
        busGrant = 1'b1;

        // Reset in the middle of a strobe.
        dtack_dly = 5; busDataIn = 16'h7777;
        rc = rsp_count;
        issue(1'b0, 24'h000400, 2'b11, 16'h0000);
        viol = 1;
        for (int n = 0; n < 10 && viol != 0; n++) begin
            @(negedge clk8);
            if (!_busAS) viol = 0;
        end
        chk("rst_mid_reach_strobe", 32'(viol), 32'd0);
        @(negedge clk8);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_strobes", {29'd0, _busAS, _busUDS, _busLDS}, 32'd7);
        chk("rst_mid_busreq", {31'd0, busRequest}, 32'd0);
        chk("rst_mid_addr", {8'd0, busAddr}, 32'd0);
        repeat (3) @(negedge clk8);
        reset = 1'b0;
        repeat (5) @(negedge clk8);
        #1;
        chk("rst_mid_no_rsp", 32'(rsp_count - rc), 32'd0);
        chk("rst_mid_ready", {31'd0, cmdReady}, 32'd1);
        dtack_dly = 0; busDataIn = 16'h1234;
        sb.push_back('{16'h1234, 1'b0});
        issue(1'b0, 24'h000402, 2'b11, 16'h0000);
        wait_rsp();
        post_chk();
        last_rd = 16'h1234;

        // Back-to-back with cmdValid held; first cycle has DTACK stuck low.
        stuck = 1'b1; dtack_dly = 0;
        cmdWrite = 1'b1; cmdAddr = 24'h000500; cmdByteEn = 2'b10; cmdData = 16'h5555;
        cmdValid = 1'b1;
        @(negedge clk8);
        acc = cyc;
        chk("b2b_accept_a", {31'd0, cmdReady}, 32'd0);
        sb.push_back('{last_rd, 1'b1});
        cmdWrite = 1'b0; cmdAddr = 24'h000600; cmdByteEn = 2'b11; busDataIn = 16'h9ABC;
        sb.push_back('{16'h9ABC, 1'b0});
        wait_rsp();
        stuck = 1'b0;
        post_chk();
        @(negedge clk8);
        acc = cyc;
        chk("b2b_accept_b", {31'd0, cmdReady}, 32'd0);
        cmdValid = 1'b0;
        wait_rsp();
        chk("b2b_latency", 32'(lat), 32'd4);
        post_chk();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
